fcore_dma_sequencer: RTL and testbench

Sequences one control-loop iteration of an fCore processor instance. On a sample trigger it:
- snapshots the input words and writes them into the core's DMA input addresses;
- pulses the core start and waits for completion;
- reads back the DMA output addresses and publishes them as one coherent result vector.

It sits between the acquisition/sampling logic and the processor instance. Default DMA map: Current at 1, Speed at 2, duty at 15.

---
 rtl/fcore_dma_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fcore_dma_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fcore_dma_sequencer.sv
// Runs one fCore control-loop iteration: DMA-load snapshot, start core,
// wait for done, DMA-read results and publish them as one vector.
module fcore_dma_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int N_INPUTS       = 2,
  parameter int N_OUTPUTS      = 1,
  parameter logic [N_INPUTS*ADDR_WIDTH-1:0]  INPUT_ADDRESSES  = {8'd2, 8'd1},
  parameter logic [N_OUTPUTS*ADDR_WIDTH-1:0] OUTPUT_ADDRESSES = {8'd15},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             trigger,
  input  logic [N_INPUTS*DATA_WIDTH-1:0]   inputs_data,
  output logic                             dma_write_valid,
  output logic [ADDR_WIDTH-1:0]            dma_write_addr,
  output logic [DATA_WIDTH-1:0]            dma_write_data,
  output logic                             core_start,
  input  logic                             core_done,
  output logic [ADDR_WIDTH-1:0]            dma_read_addr,
  input  logic [DATA_WIDTH-1:0]            dma_read_data,
  output logic [N_OUTPUTS*DATA_WIDTH-1:0]  outputs_data,
  output logic                             outputs_valid,
  output logic                             busy,
  output logic                             overrun,
  output logic [15:0]                      overrun_count,
  output logic                             timeout_fault
);

  localparam int IW = 5;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] NI_LAST = IW'(N_INPUTS - 1);
  localparam logic [IW-1:0] NO_CNT  = IW'(N_OUTPUTS);
  localparam logic [IW-1:0] NO_LAST = IW'(N_OUTPUTS - 1);
  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_PUBLISH
  } state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [N_INPUTS*DATA_WIDTH-1:0]  snap_q, snap_d;
  logic [TW-1:0]                   tmo_q, tmo_d;
  logic                            cap_vld_q, cap_vld_d;
  logic [IW-1:0]                   cap_idx_q, cap_idx_d;
  logic [N_OUTPUTS*DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [N_OUTPUTS*DATA_WIDTH-1:0] out_q, out_d;
  logic [ADDR_WIDTH-1:0]           raddr_q, raddr_d;
  logic [15:0]                     ovr_q, ovr_d;

  logic accept;
  logic tmo_hit;
  logic rd_active;

  assign accept    = trigger && enable;
  assign tmo_hit   = (state_q == S_WAIT) && !core_done && (tmo_q == TMO);
  assign rd_active = (state_q == S_READ) && (idx_q < NO_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      tmo_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      shadow_q  <= '0;
      out_q     <= '0;
      raddr_q   <= '0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      tmo_q     <= tmo_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      raddr_q   <= raddr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = S_LOAD;
      S_LOAD:    if (idx_q == NI_LAST) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        if (core_done)    state_d = S_READ;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_READ:    if (idx_q == NO_CNT) state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // READ lasts one extra drain cycle so the final read word lands in the
  // shadow; outputs are loaded together with that last word.
  always_comb begin
    idx_d     = idx_q;
    snap_d    = snap_q;
    tmo_d     = tmo_q;
    raddr_d   = raddr_q;
    shadow_d  = shadow_q;
    out_d     = out_q;
    ovr_d     = ovr_q;
    cap_vld_d = rd_active;
    cap_idx_d = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          snap_d = inputs_data;
          idx_d  = '0;
        end
      end
      S_LOAD:  idx_d = (idx_q == NI_LAST) ? '0 : idx_q + 1'b1;
      S_START: tmo_d = '0;
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        idx_d = '0;
      end
      S_READ: begin
        idx_d = idx_q + 1'b1;
        if (rd_active)
          raddr_d = OUTPUT_ADDRESSES[int'(idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      default: ;
    endcase
    if (cap_vld_q) begin
      shadow_d[int'(cap_idx_q)*DATA_WIDTH +: DATA_WIDTH] = dma_read_data;
      if (cap_idx_q == NO_LAST) out_d = shadow_d;
    end
    if (overrun && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
  end

  always_comb begin
    dma_write_valid = 1'b0;
    dma_write_addr  = '0;
    dma_write_data  = '0;
    dma_read_addr   = raddr_q;
    if (state_q == S_LOAD) begin
      dma_write_valid = 1'b1;
      dma_write_addr  = INPUT_ADDRESSES[int'(idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
      dma_write_data  = snap_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (rd_active)
      dma_read_addr = OUTPUT_ADDRESSES[int'(idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
    core_start    = (state_q == S_START);
    outputs_valid = (state_q == S_PUBLISH);
    busy          = (state_q != S_IDLE);
    overrun       = accept && (state_q != S_IDLE);
    timeout_fault = tmo_hit;
    outputs_data  = out_q;
    overrun_count = ovr_q;
  end

endmodule

// File: tb/tb_fcore_dma_sequencer.sv
// Directed bench for fcore_dma_sequencer: 2 inputs, 3 outputs
// (addresses 15,16,17), 64-cycle timeout.
module tb_fcore_dma_sequencer;

  localparam logic [95:0] P  = 96'h00000033_00000022_00000011;
  localparam logic [95:0] PB = 96'h000000C3_000000B2_000000A1;
  localparam logic [63:0] D0 = 64'h00000200_00000100;
  localparam logic [63:0] D7 = 64'h00000007_00000007;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        trigger;
  logic [63:0] inputs_data;
  logic        dma_write_valid;
  logic [7:0]  dma_write_addr;
  logic [31:0] dma_write_data;
  logic        core_start;
  logic        core_done;
  logic [7:0]  dma_read_addr;
  logic [31:0] dma_read_data;
  logic [95:0] outputs_data;
  logic        outputs_valid;
  logic        busy;
  logic        overrun;
  logic [15:0] overrun_count;
  logic        timeout_fault;

  fcore_dma_sequencer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .N_INPUTS(2), .N_OUTPUTS(3),
    .INPUT_ADDRESSES({8'd2, 8'd1}),
    .OUTPUT_ADDRESSES({8'd17, 8'd16, 8'd15}),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .trigger(trigger),
    .inputs_data(inputs_data),
    .dma_write_valid(dma_write_valid), .dma_write_addr(dma_write_addr),
    .dma_write_data(dma_write_data), .core_start(core_start),
    .core_done(core_done), .dma_read_addr(dma_read_addr),
    .dma_read_data(dma_read_data), .outputs_data(outputs_data),
    .outputs_valid(outputs_valid), .busy(busy), .overrun(overrun),
    .overrun_count(overrun_count), .timeout_fault(timeout_fault)
  );

  always #5 clock = ~clock;

  // core DMA memory: one-cycle read latency
  logic [31:0] mem [0:255];
  always @(posedge clock) dma_read_data <= mem[dma_read_addr];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        t, e, d;
    logic [63:0] din;
    logic        wv;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        st;
    logic [7:0]  ra;
    logic        ov;
    logic [95:0] od;
    logic        bz, ovr;
  } vec_t;

  function automatic vec_t mk(
    logic t, logic e, logic d, logic [63:0] din,
    logic wv, logic [7:0] wa, logic [31:0] wd, logic st,
    logic [7:0] ra, logic ov, logic [95:0] od, logic bz, logic ovr);
    vec_t v;
    v.t = t; v.e = e; v.d = d; v.din = din;
    v.wv = wv; v.wa = wa; v.wd = wd; v.st = st;
    v.ra = ra; v.ov = ov; v.od = od; v.bz = bz; v.ovr = ovr;
    return v;
  endfunction

  function automatic logic [159:0] obs();
    return {dma_write_valid, dma_write_addr, dma_write_data, core_start,
            dma_read_addr, outputs_valid, outputs_data, busy, overrun};
  endfunction

  function automatic logic [159:0] all_out();
    return {obs(), overrun_count, timeout_fault};
  endfunction

  vec_t tbl [19];
  int   ovc, tfc, bad, pubs, pubk, n, ovs;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[15] = 32'h11; mem[16] = 32'h22; mem[17] = 32'h33;
    reset = 1'b0; enable = 1'b0; trigger = 1'b0;
    core_done = 1'b0; inputs_data = '0;

    tbl[0]  = mk(1,0,0,'0, 0,0,0,0, 0,0,'0,0,0);
    tbl[1]  = mk(0,1,0,'0, 0,0,0,0, 0,0,'0,0,0);
    tbl[2]  = mk(1,1,0,D0, 0,0,0,0, 0,0,'0,0,0);
    tbl[3]  = mk(0,1,0,D7, 1,1,32'h100,0, 0,0,'0,1,0);
    tbl[4]  = mk(0,1,1,D7, 1,2,32'h200,0, 0,0,'0,1,0);
    tbl[5]  = mk(0,1,0,D7, 0,0,0,1, 0,0,'0,1,0);
    tbl[6]  = mk(0,1,0,D7, 0,0,0,0, 0,0,'0,1,0);
    tbl[7]  = mk(1,1,0,D7, 0,0,0,0, 0,0,'0,1,1);
    tbl[8]  = mk(0,0,0,D7, 0,0,0,0, 0,0,'0,1,0);
    tbl[9]  = mk(0,0,0,D7, 0,0,0,0, 0,0,'0,1,0);
    tbl[10] = mk(0,0,0,D7, 0,0,0,0, 0,0,'0,1,0);
    tbl[11] = mk(0,0,0,D7, 0,0,0,0, 0,0,'0,1,0);
    tbl[12] = mk(0,0,1,D7, 0,0,0,0, 0,0,'0,1,0);
    tbl[13] = mk(0,0,0,D7, 0,0,0,0, 15,0,'0,1,0);
    tbl[14] = mk(0,0,0,D7, 0,0,0,0, 16,0,'0,1,0);
    tbl[15] = mk(0,0,0,D7, 0,0,0,0, 17,0,'0,1,0);
    tbl[16] = mk(0,0,0,D7, 0,0,0,0, 17,0,'0,1,0);
    tbl[17] = mk(1,1,0,D7, 0,0,0,0, 17,1,P,1,1);
    tbl[18] = mk(0,1,0,D7, 0,0,0,0, 17,0,P,0,0);

    #2 reset = 1'b1;
    #2 chk("reset_state", all_out(), '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // nominal iteration, snapshot, ignored done, overrun in WAIT/PUBLISH
    for (int i = 0; i < 19; i++) begin
      trigger = tbl[i].t; enable = tbl[i].e;
      core_done = tbl[i].d; inputs_data = tbl[i].din;
      @(negedge clock);
      chk($sformatf("vec%0d", i), obs(),
          {tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].st, tbl[i].ra,
           tbl[i].ov, tbl[i].od, tbl[i].bz, tbl[i].ovr});
      @(posedge clock); #1;
    end
    trigger = 1'b0;
    chk("ovr_count2", overrun_count, 16'd2);

    // timeout: WAIT entered at k=4, fault at k=68, trigger there dropped
    ovc = 0; tfc = 0;
    for (int k = 0; k <= 70; k++) begin
      trigger = (k == 0 || k == 68); enable = 1'b1; core_done = 1'b0;
      @(negedge clock);
      if (outputs_valid) ovc++;
      if (timeout_fault) tfc++;
      if (k == 67) chk("tmo_early", timeout_fault, 0);
      if (k == 68) chk("tmo_pulse", {timeout_fault, overrun}, 2'b11);
      if (k == 69) chk("tmo_idle", {busy, overrun}, 0);
      @(posedge clock); #1;
    end
    trigger = 1'b0;
    chk("tmo_nopub", ovc, 0);
    chk("tmo_once", tfc, 1);
    chk("tmo_od_kept", outputs_data, P);
    chk("tmo_ovr_cnt", overrun_count, 16'd3);

    // async reset in WAIT, then stray done, then clean iteration
    trigger = 1'b1; inputs_data = 64'h5;
    @(posedge clock); #1;
    trigger = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1 chk("rst_async", all_out(), '0);
    @(posedge clock); #1;
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      core_done = (c == 0);
      @(negedge clock);
      if (busy || outputs_valid || dma_read_addr != 8'd0 ||
          dma_write_valid || core_start) bad++;
      @(posedge clock); #1;
    end
    core_done = 1'b0;
    chk("rst_quiet", bad, 0);

    mem[15] = 32'hA1; mem[16] = 32'hB2; mem[17] = 32'hC3;
    inputs_data = 64'h00000444_00000333;
    pubs = 0; pubk = -1;
    for (int k = 0; k < 20; k++) begin
      trigger = (k == 0); core_done = (k == 4);
      @(negedge clock);
      if (k == 1) chk("clean_w0", {dma_write_valid, dma_write_addr,
                                   dma_write_data}, {1'b1, 8'd1, 32'h333});
      if (k == 2) chk("clean_w1", {dma_write_valid, dma_write_addr,
                                   dma_write_data}, {1'b1, 8'd2, 32'h444});
      if (k == 3) chk("clean_start", core_start, 1);
      if (outputs_valid) begin
        pubs++; pubk = k;
        chk("clean_od", outputs_data, PB);
      end
      @(posedge clock); #1;
    end
    core_done = 1'b0; trigger = 1'b0;
    chk("clean_pubs", pubs, 1);
    chk("clean_pub_cycle", pubk, 9);

    // saturation: trigger held high, core never completes
    trigger = 1'b1; enable = 1'b1; n = 0;
    while (overrun_count != 16'hFFFF && n < 70000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("sat_reach", overrun_count, 16'hFFFF);
    ovs = 0;
    repeat (200) begin
      @(negedge clock);
      if (overrun) ovs++;
      @(posedge clock); #1;
    end
    trigger = 1'b0;
    chk("sat_hold", overrun_count, 16'hFFFF);
    chk("sat_pulses", ovs > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
